div3_issue_ctrl: RTL and testbench
==================================

Name: div3_issue_ctrl

Overview:
- Upstream sequencer for the divide-by-3 unit; sits between a ready/valid sample source and the divider's divident/select interface.
- Buffers incoming samples in a small FIFO and issues each one as a single-cycle select pulse, spaced by the divider's busy window.
- Drives a fixed-latency sampler that captures quotient/reminder DIV_LATENCY cycles after each pulse and emits a tagged result strobe.

Parameters:
DATA_WIDTH, 20, width of divident/quotient
FIFO_DEPTH, 4, sample buffer entries (power of 2, >=2)
ISSUE_GAP, 5, cycles from one select pulse to the next (>=2)
DIV_LATENCY, 4, cycles from select-high cycle to quotient/reminder valid; must satisfy 1 <= DIV_LATENCY <= ISSUE_GAP-1, elaboration $error otherwise

Ports:
sys_clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
in_valid  in  1  sample available
in_ready  out  1  FIFO can accept (= !full)
in_data  in  DATA_WIDTH  sample to divide
divident  out  DATA_WIDTH  to divider; held from issue until next issue
select  out  1  to divider; one-cycle start pulse
quotient  in  DATA_WIDTH  from divider
reminder  in  2  from divider
out_valid  out  1  one-cycle result strobe
out_quotient  out  DATA_WIDTH  captured quotient
out_reminder  out  2  captured reminder
out_divident  out  DATA_WIDTH  divident that produced this result
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
check_error  out  1  consistency flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, fifo_count=0, in_ready=1 one cycle after deassert, select=0, divident=0, out_valid=0, out_* = 0, check_error=0, FSM=IDLE; any pending capture is dropped.
- FIFO: push when in_valid&&in_ready; in_ready = !full (no write-through when full, even with same-cycle pop). Simultaneous push+pop when not full/empty: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: if FIFO non-empty -> ISSUE next cycle. Pushing into an empty FIFO gives select at the earliest 2 cycles after the push cycle.
- ISSUE (1 cycle): select=1, divident<=head entry (registered, stable while select high), pop; gap counter loads ISSUE_GAP-1 -> WAIT.
- WAIT: counts down; at 0 -> ISSUE if FIFO non-empty, else IDLE. Back-to-back select pulses are exactly ISSUE_GAP cycles apart.
- Capture: the ISSUE cycle starts a latency counter; DIV_LATENCY cycles later quotient/reminder are registered into out_quotient/out_reminder, out_divident <= issued divident, and out_valid is high for that one cycle.
- DIV_LATENCY < ISSUE_GAP guarantees at most one capture in flight; no result queue.
- No output backpressure: the consumer must accept every out_valid.
- Reset mid-WAIT or mid-capture: no out_valid is produced for the aborted sample.

Optional Feature:
- Macro DIV3_CHECK_EN.
- Defined: at capture, check_error is registered as (out_quotient*3 + out_reminder != out_divident) || (reminder == 3). Arithmetic is done at DATA_WIDTH+2 bits. The flag is sticky until reset.
- Undefined: check_error is tied 0 and the check logic is absent.

Decomposition:
- div3_pkg: DATA_WIDTH default; FSM enum {IDLE, ISSUE, WAIT}; result struct {quotient, reminder, divident}.
- Sub-module div3_sample_fifo: parameterised synchronous FIFO providing full, empty and count, on the same clock and reset.

Test Plan:
1. Reset held 20 ns, release -> in_ready=1, fifo_count=0, select=0, out_valid=0; no activity for 10 cycles.
2. Push 77689 into empty FIFO -> select pulses once with divident=77689; DIV_LATENCY cycles later out_valid=1 with out_quotient=25896, out_reminder=1, out_divident=77689 (real divider downstream, reset_n = ~reset).
3. Push 77689, 77690, 77691 on consecutive cycles -> select pulses exactly 5 cycles apart; results (25896,1), (25896,2), (25897,0) in order.
4. Hold in_valid high for 10 cycles with an incrementing counter -> in_ready drops when fifo_count=4; no sample lost or duplicated; all 10 results are correct and in order.
5. Assert reset 2 cycles after a select pulse -> no out_valid for that sample; FIFO empty; after release, a new push gives a normal result.
6. With DIV3_CHECK_EN defined, force reminder=3 on one capture -> check_error=1 and stays 1 until reset. Without the macro, the same stimulus leaves check_error=0.

Source files
------------

// File: rtl/div3_pkg.sv
// div3_pkg: shared types and defaults for the divide-by-3 issue controller.
package div3_pkg;
    localparam int DIV3_DATA_WIDTH = 20;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef struct packed {
        logic [DIV3_DATA_WIDTH-1:0] quotient;
        logic [1:0]                 reminder;
        logic [DIV3_DATA_WIDTH-1:0] divident;
    } result_t;
endpackage

// File: rtl/div3_sample_fifo.sv
// div3_sample_fifo: synchronous FIFO with full/empty/count; no write-through when full.
module div3_sample_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_push, w_pop;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = r_count == (AW+1)'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];
    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end
endmodule

// File: rtl/div3_issue_ctrl.sv
// div3_issue_ctrl: buffers samples, issues spaced select pulses, captures divider results.
// Optional result consistency check enabled by DIV3_CHECK_EN.
module div3_issue_ctrl
    import div3_pkg::*;
#(
    parameter int DATA_WIDTH  = DIV3_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int ISSUE_GAP   = 5,
    parameter int DIV_LATENCY = 4
) (
    input  logic                          sys_clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [DATA_WIDTH-1:0]         divident,
    output logic                          select,
    input  logic [DATA_WIDTH-1:0]         quotient,
    input  logic [1:0]                    reminder,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_quotient,
    output logic [1:0]                    out_reminder,
    output logic [DATA_WIDTH-1:0]         out_divident,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          check_error
);
    localparam int GW = $clog2(ISSUE_GAP);
    localparam int LW = $clog2(DIV_LATENCY + 1);

    if (DIV_LATENCY < 1 || DIV_LATENCY > ISSUE_GAP - 1) begin : g_bad_latency
        $error("DIV_LATENCY must be in 1..ISSUE_GAP-1");
    end

    state_t                r_state;
    logic [GW-1:0]         r_gap;
    logic [LW-1:0]         r_lat;
    logic                  r_busy, r_select, r_out_valid;
    logic [DATA_WIDTH-1:0] r_divident, r_out_quotient, r_out_divident;
    logic [1:0]            r_out_reminder;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_full, w_empty, w_issue, w_cap;

    div3_sample_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clock),
        .rst   (reset),
        .push  (in_valid),
        .pop   (w_issue),
        .wdata (in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    // Decision is made one cycle ahead so select and divident come out registered.
    assign w_issue = !w_empty && (r_state == IDLE || (r_state == WAIT && r_gap == '0));
    assign w_cap   = r_busy && r_lat == '0;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_gap          <= '0;
            r_lat          <= '0;
            r_busy         <= 1'b0;
            r_select       <= 1'b0;
            r_divident     <= '0;
            r_out_valid    <= 1'b0;
            r_out_quotient <= '0;
            r_out_reminder <= '0;
            r_out_divident <= '0;
        end else begin
            r_select    <= w_issue;
            r_state     <= w_issue ? ISSUE :
                           r_state == ISSUE ? WAIT :
                           (r_state == WAIT && r_gap == '0) ? IDLE : r_state;
            r_gap       <= w_issue ? GW'(ISSUE_GAP - 1) : (r_gap != '0 ? r_gap - 1'b1 : r_gap);
            r_lat       <= w_issue ? LW'(DIV_LATENCY) : (r_lat != '0 ? r_lat - 1'b1 : r_lat);
            r_busy      <= w_issue || (r_busy && !w_cap);
            r_out_valid <= w_cap;
            if (w_issue) r_divident <= w_head;
            // r_divident still holds the captured sample even if a new issue lands this edge.
            if (w_cap) begin
                r_out_quotient <= quotient;
                r_out_reminder <= reminder;
                r_out_divident <= r_divident;
            end
        end
    end

    assign in_ready     = !w_full;
    assign select       = r_select;
    assign divident     = r_divident;
    assign out_valid    = r_out_valid;
    assign out_quotient = r_out_quotient;
    assign out_reminder = r_out_reminder;
    assign out_divident = r_out_divident;

`ifdef DIV3_CHECK_EN
    localparam int XW = DATA_WIDTH + 2;
    logic          r_check;
    logic [XW-1:0] w_sum;
    assign w_sum = XW'(quotient) * XW'(3) + XW'(reminder);
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) r_check <= 1'b0;
        else if (w_cap && (w_sum != XW'(r_divident) || reminder == 2'd3)) r_check <= 1'b1;
    end
    assign check_error = r_check;
`else
    assign check_error = 1'b0;
`endif
endmodule

// File: tb/tb_div3_issue_ctrl.sv
// tb_div3_issue_ctrl: directed vector bench for div3_issue_ctrl with a fixed-latency divider model.
module tb_div3_issue_ctrl;
    import div3_pkg::*;
    localparam int DW = 20, FD = 4, IG = 5, DL = 4;

    logic                  sys_clock = 0, reset = 1, in_valid = 0, force_r3 = 0;
    logic [DW-1:0]         in_data = '0;
    logic                  in_ready, select, out_valid, check_error;
    logic [DW-1:0]         divident, quotient, out_quotient, out_divident;
    logic [1:0]            reminder, out_reminder;
    logic [$clog2(FD):0]   fifo_count;

    div3_issue_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ISSUE_GAP(IG), .DIV_LATENCY(DL)) dut (
        .sys_clock(sys_clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .divident(divident), .select(select), .quotient(quotient),
        .reminder(reminder), .out_valid(out_valid), .out_quotient(out_quotient),
        .out_reminder(out_reminder), .out_divident(out_divident), .fifo_count(fifo_count),
        .check_error(check_error));

    always #5 sys_clock = ~sys_clock;

    // Divider model: result valid only in the cycle DL cycles after the select cycle.
    logic [DW-1:0] dpipe [DL];
    logic [DL-1:0] vpipe;
    always @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            vpipe <= '0;
            for (int i = 0; i < DL; i++) dpipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[DL-2:0], select};
            dpipe[0] <= divident;
            for (int i = 1; i < DL; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign quotient = vpipe[DL-1] ? dpipe[DL-1] / 3 : '1;
    assign reminder = force_r3 ? 2'd3 : vpipe[DL-1] ? 2'(dpipe[DL-1] % 3) : 2'd0;

    int checks = 0, errors = 0, nres = 0, nsel = 0, cyc = 0, last_sel = -1, saw_full = 0;
    bit chk_gap = 0, sb_en = 1;
    result_t vt [16];
    result_t exp_q [$];
    logic [DW-1:0] iss_q [$];
    result_t m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge sys_clock) begin
        cyc++;
        if (!reset) begin
            if (fifo_count == FD) begin
                saw_full++;
                check("in_ready_full", 64'(in_ready), 64'(0));
            end
            if (select) begin
                nsel++;
                if (chk_gap && last_sel >= 0) check("select_gap", 64'(cyc - last_sel), 64'(IG));
                last_sel = cyc;
                if (iss_q.size() == 0) check("select_unexpected", 64'(select), 64'(0));
                else check("issue_divident", 64'(divident), 64'(iss_q.pop_front()));
            end
            if (out_valid) begin
                nres++;
                if (sb_en) begin
                    if (exp_q.size() == 0) check("out_valid_unexpected", 64'(out_valid), 64'(0));
                    else begin
                        m_e = exp_q.pop_front();
                        check("out_quotient", 64'(out_quotient), 64'(m_e.quotient));
                        check("out_reminder", 64'(out_reminder), 64'(m_e.reminder));
                        check("out_divident", 64'(out_divident), 64'(m_e.divident));
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic push(input result_t e);
        logic acc = 0;
        in_valid = 1;
        in_data  = e.divident;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = in_ready;
            if (acc) begin
                exp_q.push_back(e);
                iss_q.push_back(e.divident);
            end
            @(negedge sys_clock);
        end
        if (!acc) check("push_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic wait_results(input int target, input int budget);
        for (int t = 0; t < budget && nres < target; t++) @(negedge sys_clock);
        @(negedge sys_clock);
        check("result_count", 64'(nres), 64'(target));
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        exp_q.delete();
        iss_q.delete();
        repeat (n) @(negedge sys_clock);
        reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, s0;
        logic got;
        vt = '{'{20'd25896, 2'd1, 20'd77689}, '{20'd25896, 2'd2, 20'd77690}, '{20'd25897, 2'd0, 20'd77691},
               '{20'd33, 2'd1, 20'd100}, '{20'd33, 2'd2, 20'd101}, '{20'd34, 2'd0, 20'd102},
               '{20'd34, 2'd1, 20'd103}, '{20'd34, 2'd2, 20'd104}, '{20'd35, 2'd0, 20'd105},
               '{20'd35, 2'd1, 20'd106}, '{20'd35, 2'd2, 20'd107}, '{20'd36, 2'd0, 20'd108},
               '{20'd36, 2'd1, 20'd109}, '{20'd349525, 2'd0, 20'd1048575},
               '{20'd349524, 2'd2, 20'd1048574}, '{20'd0, 2'd0, 20'd0}};
        // 1: reset state and quiet idle
        #20 reset = 0;
        @(negedge sys_clock);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_fifo_count", 64'(fifo_count), 64'(0));
        check("rst_select", 64'(select), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_divident", 64'(divident), 64'(0));
        check("rst_out_quotient", 64'(out_quotient), 64'(0));
        check("rst_check_error", 64'(check_error), 64'(0));
        s0 = nsel;
        repeat (10) @(negedge sys_clock);
        check("idle_no_select", 64'(nsel), 64'(s0));
        // 2: single sample, exact issue and capture timing
        push(vt[0]);
        in_valid = 0;
        check("t2_count_after_push", 64'(fifo_count), 64'(1));
        check("t2_select_early", 64'(select), 64'(0));
        @(negedge sys_clock);
        check("t2_select", 64'(select), 64'(1));
        check("t2_divident", 64'(divident), 64'(77689));
        @(negedge sys_clock);
        check("t2_select_one_cycle", 64'(select), 64'(0));
        check("t2_divident_held", 64'(divident), 64'(77689));
        repeat (DL - 1) @(negedge sys_clock);
        check("t2_out_valid_early", 64'(out_valid), 64'(0));
        @(negedge sys_clock);
        check("t2_out_valid", 64'(out_valid), 64'(1));
        @(negedge sys_clock);
        check("t2_out_valid_pulse", 64'(out_valid), 64'(0));
        // 3: back-to-back issues spaced by ISSUE_GAP
        chk_gap = 1;
        last_sel = -1;
        r0 = nres;
        for (int i = 0; i < 3; i++) push(vt[i]);
        in_valid = 0;
        wait_results(r0 + 3, 60);
        chk_gap = 0;
        // 4: continuous source fills the FIFO
        saw_full = 0;
        r0 = nres;
        for (int i = 3; i < 13; i++) push(vt[i]);
        in_valid = 0;
        wait_results(r0 + 10, 120);
        check("t4_saw_full", 64'(saw_full > 0), 64'(1));
        // 5: reset two cycles after a select pulse drops the capture and the FIFO
        push(vt[13]);
        in_valid = 0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge sys_clock);
            got = select;
        end
        check("t5_select_seen", 64'(got), 64'(1));
        push(vt[15]);
        in_valid = 0;
        @(negedge sys_clock);
        reset = 1;
        exp_q.delete();
        iss_q.delete();
        @(negedge sys_clock);
        check("t5_fifo_empty", 64'(fifo_count), 64'(0));
        check("t5_select_rst", 64'(select), 64'(0));
        reset = 0;
        r0 = nres;
        repeat (12) @(negedge sys_clock);
        check("t5_no_result", 64'(nres), 64'(r0));
        check("t5_fifo_still_empty", 64'(fifo_count), 64'(0));
        push(vt[14]);
        in_valid = 0;
        wait_results(r0 + 1, 30);
        // 6: forced reminder of 3 on one capture
        check("t6_check_clear", 64'(check_error), 64'(0));
        sb_en = 0;
        force_r3 = 1;
        push(vt[15]);
        in_valid = 0;
        got = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(negedge sys_clock);
            got = out_valid;
        end
        force_r3 = 0;
        check("t6_capture_seen", 64'(got), 64'(1));
        check("t6_out_reminder", 64'(out_reminder), 64'(3));
        @(negedge sys_clock);
`ifdef DIV3_CHECK_EN
        check("t6_check_error", 64'(check_error), 64'(1));
        repeat (6) @(negedge sys_clock);
        check("t6_check_sticky", 64'(check_error), 64'(1));
`else
        check("t6_check_error_off", 64'(check_error), 64'(0));
        repeat (6) @(negedge sys_clock);
        check("t6_check_error_off_later", 64'(check_error), 64'(0));
`endif
        do_reset(2);
        sb_en = 1;
        @(negedge sys_clock);
        check("t6_check_after_reset", 64'(check_error), 64'(0));
        check("t6_out_reminder_reset", 64'(out_reminder), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
